// File: rtl/rst_seq_pkg.sv
// Shared definitions for the staged reset sequencer: state encoding,
// stage-index width helper and default timing constants.
package rst_seq_pkg;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } seq_state_e;

   localparam int DEF_NUM_CH     = 4;
   localparam int DEF_POR_CYCLES = 2500;
   localparam int DEF_STAGE_GAP  = 16;
   localparam int DEF_SOFT_HOLD  = 64;
   localparam int DEF_CNT_W      = 16;

   // Stage index needs at least one bit even for a single channel.
   function automatic int stg_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rst_stage_timer.sv
// Loadable up-counter with a terminal-count pulse; times both the hold
// interval and the gaps between channel releases.
module rst_stage_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] limit,
   output logic             tc
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // limit is the last count value, so the count never needs to reach the
   // full interval length and cannot overflow.
   assign tc = !load && (cnt_q == limit);

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (load || tc) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/rst_sequencer.sv
// Multi-channel reset sequencer: power-on hold, ordered per-channel release
// and masked soft reset that re-sequences only the selected channels.
module rst_sequencer
   import rst_seq_pkg::*;
#(
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int POR_CYCLES = DEF_POR_CYCLES,
   parameter int STAGE_GAP  = DEF_STAGE_GAP,
   parameter int SOFT_HOLD  = DEF_SOFT_HOLD,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              soft_req,
   input  logic [NUM_CH-1:0] ch_mask,
   output logic [NUM_CH-1:0] rst_out,
   output logic              seq_done,
   output logic              busy
);

   localparam int STG_W = stg_width(NUM_CH);
   localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYCLES - 1);
   localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_HOLD - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

   seq_state_e        state_q, state_d;
   logic [STG_W-1:0]  stg_q, stg_d;
   logic [CNT_W-1:0]  hold_last_q, hold_last_d;
   logic [NUM_CH-1:0] rst_out_q, rst_out_d;
   logic              seq_done_q, seq_done_d;
   logic              busy_q, busy_d;

   logic              timer_load;
   logic              timer_tc;
   logic [CNT_W-1:0]  timer_limit;
   logic [NUM_CH-1:0] next_sel;

   assign timer_load  = (state_q == ST_RUN);
   assign timer_limit = (state_q == ST_HOLD) ? hold_last_q : GAP_LAST;

   rst_stage_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (timer_load),
      .limit (timer_limit),
      .tc    (timer_tc)
   );

   // One-hot select of the channel released at the end of the current gap.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sel
      assign next_sel[gi] = (gi == int'(stg_q) + 1);
   end

   always_comb begin
      state_d     = state_q;
      stg_d       = stg_q;
      hold_last_d = hold_last_q;
      rst_out_d   = rst_out_q;
      unique case (state_q)
         ST_HOLD: begin
            if (timer_tc) begin
               rst_out_d[0] = 1'b1;
               stg_d        = '0;
               state_d      = (NUM_CH == 1) ? ST_RUN : ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (timer_tc) begin
               rst_out_d = rst_out_q | next_sel;
               stg_d     = stg_q + STG_W'(1);
               if (int'(stg_q) + 1 >= NUM_CH - 1) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (soft_req && (|ch_mask)) begin
               rst_out_d   = rst_out_q & ~ch_mask;
               hold_last_d = SOFT_LAST;
               stg_d       = '0;
               state_d     = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_HOLD;
         end
      endcase
      seq_done_d = (state_d == ST_RUN);
      busy_d     = (state_d == ST_HOLD) || (state_d == ST_RELEASE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_HOLD;
         stg_q       <= '0;
         hold_last_q <= POR_LAST;
         rst_out_q   <= '0;
         seq_done_q  <= 1'b0;
         busy_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         stg_q       <= stg_d;
         hold_last_q <= hold_last_d;
         rst_out_q   <= rst_out_d;
         seq_done_q  <= seq_done_d;
         busy_q      <= busy_d;
      end
   end

   assign rst_out  = rst_out_q;
   assign seq_done = seq_done_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: power-on timing, masked soft reset,
// ignored requests, reset mid-sequence and back-to-back soft requests.
module tb_rst_sequencer;

   logic       clk;
   logic       rst;
   logic       soft_req;
   logic [3:0] ch_mask;
   logic [3:0] rst_out;
   logic       seq_done;
   logic       busy;

   int checks = 0;
   int errors = 0;

   rst_sequencer #(
      .NUM_CH     (4),
      .POR_CYCLES (2500),
      .STAGE_GAP  (16),
      .SOFT_HOLD  (64),
      .CNT_W      (16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .soft_req (soft_req),
      .ch_mask  (ch_mask),
      .rst_out  (rst_out),
      .seq_done (seq_done),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n active edges and sample 1 time unit after the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
      $display("check %-24s observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      logic low_seen;

      rst      = 1'b0;
      soft_req = 1'b0;
      ch_mask  = 4'b0000;

      // Power-on: five edges in reset, the last one is E0.
      tick(5);
      chk("por_reset_rst_out", 32'(rst_out), 32'h0);
      chk("por_reset_seq_done", 32'(seq_done), 32'h0);
      chk("por_reset_busy", 32'(busy), 32'h1);
      rst = 1'b1;

      // Soft request pulsed at E0+100 during POR hold must be ignored.
      tick(99);
      soft_req = 1'b1;
      ch_mask  = 4'b1111;
      tick(1);
      soft_req = 1'b0;
      ch_mask  = 4'b0000;
      chk("por_e100_rst_out", 32'(rst_out), 32'h0);
      chk("por_e100_busy", 32'(busy), 32'h1);

      tick(2399);
      chk("por_e2499", 32'(rst_out), 32'h0);
      tick(1);
      chk("por_e2500", 32'(rst_out), 32'h1);
      tick(15);
      chk("por_e2515", 32'(rst_out), 32'h1);
      tick(1);
      chk("por_e2516", 32'(rst_out), 32'h3);
      tick(16);
      chk("por_e2532", 32'(rst_out), 32'h7);
      chk("por_e2532_seq_done", 32'(seq_done), 32'h0);
      tick(15);
      chk("por_e2547_busy", 32'(busy), 32'h1);
      tick(1);
      chk("por_e2548", 32'(rst_out), 32'hF);
      chk("por_e2548_seq_done", 32'(seq_done), 32'h1);
      chk("por_e2548_busy", 32'(busy), 32'h0);

      // Soft request with an empty mask in RUN is ignored.
      soft_req = 1'b1;
      ch_mask  = 4'b0000;
      tick(1);
      soft_req = 1'b0;
      chk("mask0_rst_out", 32'(rst_out), 32'hF);
      chk("mask0_seq_done", 32'(seq_done), 32'h1);
      tick(1);

      // Masked soft reset accepted at edge T.
      soft_req = 1'b1;
      ch_mask  = 4'b1010;
      tick(1);
      soft_req = 1'b0;
      ch_mask  = 4'b1111;
      chk("soft_t_rst_out", 32'(rst_out), 32'h5);
      chk("soft_t_busy", 32'(busy), 32'h1);
      chk("soft_t_seq_done", 32'(seq_done), 32'h0);
      low_seen = 1'b0;
      for (int k = 1; k <= 112; k++) begin
         tick(1);
         if (!rst_out[0] || !rst_out[2]) low_seen = 1'b1;
         if (k == 79) chk("soft_t79", 32'(rst_out), 32'h5);
         if (k == 80) chk("soft_t80", 32'(rst_out), 32'h7);
         if (k == 111) begin
            chk("soft_t111", 32'(rst_out), 32'h7);
            chk("soft_t111_seq_done", 32'(seq_done), 32'h0);
            // Request on the edge seq_done rises: must be ignored.
            soft_req = 1'b1;
            ch_mask  = 4'b1010;
         end
      end
      chk("soft_t112", 32'(rst_out), 32'hF);
      chk("soft_t112_seq_done", 32'(seq_done), 32'h1);
      chk("soft_bits02_held", 32'(low_seen), 32'h0);

      // Same request held one more edge (T+113) is accepted; call it T2.
      tick(1);
      soft_req = 1'b0;
      chk("b2b_t113_rst_out", 32'(rst_out), 32'h5);
      chk("b2b_t113_busy", 32'(busy), 32'h1);

      // Reset during soft hold at T2+30 drops everything and restarts POR.
      tick(29);
      chk("soft2_t29", 32'(rst_out), 32'h5);
      rst = 1'b0;
      tick(1);
      chk("rst_in_soft_rst_out", 32'(rst_out), 32'h0);
      chk("rst_in_soft_busy", 32'(busy), 32'h1);
      rst = 1'b1;
      tick(64);
      chk("rst_in_soft_e64", 32'(rst_out), 32'h0);
      tick(2435);
      chk("rst_in_soft_e2499", 32'(rst_out), 32'h0);
      tick(1);
      chk("rst_in_soft_e2500", 32'(rst_out), 32'h1);
      tick(16);
      chk("rst_in_soft_e2516", 32'(rst_out), 32'h3);

      // Reset mid-release at E0+2520; the full timing repeats from there.
      tick(3);
      rst = 1'b0;
      tick(1);
      chk("rst_mid_rst_out", 32'(rst_out), 32'h0);
      chk("rst_mid_seq_done", 32'(seq_done), 32'h0);
      rst = 1'b1;
      tick(2499);
      chk("rst_mid_e2499", 32'(rst_out), 32'h0);
      tick(1);
      chk("rst_mid_e2500", 32'(rst_out), 32'h1);
      tick(16);
      chk("rst_mid_e2516", 32'(rst_out), 32'h3);
      tick(16);
      chk("rst_mid_e2532", 32'(rst_out), 32'h7);
      tick(16);
      chk("rst_mid_e2548", 32'(rst_out), 32'hF);
      chk("rst_mid_e2548_seq_done", 32'(seq_done), 32'h1);
      chk("rst_mid_e2548_busy", 32'(busy), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
